scpad_req_arbiter: RTL and testbench

- Upstream stage of the scratchpad: merges memory requests from NUM_SRCS requesters (vector core, systolic array, DMA) into the single request channel consumed by the scratchpad frontend.
- Each source gets a small FIFO.
- A round-robin arbiter selects among non-empty FIFOs.
- A registered output stage drives the frontend with a valid/ready handshake and a source tag, so responses can be routed back.

---
 rtl/scpad_pkg.sv | 23 ++
 rtl/scpad_req_fifo.sv | 79 +++++++
 rtl/scpad_req_arbiter.sv | 106 ++++++++++
 tb/tb_scpad_req_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scpad_pkg.sv
// Shared scratchpad types: request format and requester-count constants
// used by the request arbiter and its per-source FIFOs.
package scpad_pkg;

    localparam int NUM_SCPADS   = 2;
    localparam int NUM_COLS     = 4;
    localparam int ELEM_BITS    = 8;
    localparam int ROW_ADDR_W   = 8;
    localparam int SCPAD_ID_W   = $clog2(NUM_SCPADS);

    // Requesters: vector core, systolic array, DMA
    localparam int NUM_REQ_SRCS = 3;
    localparam int SRC_ID_W     = $clog2(NUM_REQ_SRCS);

    typedef struct packed {
        logic                                 write;
        logic [SCPAD_ID_W-1:0]                scpad_id;
        logic [ROW_ADDR_W-1:0]                addr;
        logic [NUM_COLS-1:0]                  mask;
        logic [NUM_COLS-1:0][ELEM_BITS-1:0]   data;
    } scpad_req_t;

endpackage

// File: rtl/scpad_req_fifo.sv
// Small synchronous FIFO of scratchpad requests; full/empty are registered so
// the upstream ready never depends combinationally on the pop side.
module scpad_req_fifo
    import scpad_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  scpad_req_t             din,
    input  logic                   pop,
    output scpad_req_t             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    scpad_req_t         mem_r [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic               full_r;
    logic               empty_r;
    logic               push_s;
    logic               pop_s;

    // Qualified push/pop and next occupancy
    always_comb begin
        push_s      = push && !full_r;
        pop_s       = pop && !empty_r;
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + CNT_W'(1);
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - CNT_W'(1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers (wrap naturally at power-of-two depth), count and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CNT_W'(DEPTH));
            empty_r <= (count_nxt_s == CNT_W'(0));
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/scpad_req_arbiter.sv
// Merges per-source scratchpad requests into one valid/ready channel using
// round-robin arbitration over per-source FIFOs and a registered output stage.
module scpad_req_arbiter
    import scpad_pkg::*;
#(
    parameter int NUM_SRCS   = NUM_REQ_SRCS,
    parameter int FIFO_DEPTH = 4,
    parameter int SRC_ID_W   = $clog2(NUM_SRCS)
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic       [NUM_SRCS-1:0]     src_valid,
    output logic       [NUM_SRCS-1:0]     src_ready,
    input  scpad_req_t [NUM_SRCS-1:0]     src_req,
    output logic                          out_valid,
    input  logic                          out_ready,
    output scpad_req_t                    out_req,
    output logic       [SRC_ID_W-1:0]     out_src,
    output logic                          busy
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    scpad_req_t [NUM_SRCS-1:0]            fifo_dout_s;
    logic       [NUM_SRCS-1:0]            fifo_full_s;
    logic       [NUM_SRCS-1:0]            fifo_empty_s;
    logic       [NUM_SRCS-1:0][CNT_W-1:0] fifo_count_s;
    logic       [NUM_SRCS-1:0]            fifo_ne_s;
    logic       [NUM_SRCS-1:0]            push_s;
    logic       [NUM_SRCS-1:0]            pop_s;

    logic [SRC_ID_W-1:0] grant_s;
    logic [SRC_ID_W-1:0] search_s;
    logic                grant_found_s;
    logic                load_s;

    logic                out_valid_r;
    scpad_req_t          out_req_r;
    logic [SRC_ID_W-1:0] out_src_r;
    logic [SRC_ID_W-1:0] rr_last_r;

    for (genvar i = 0; i < NUM_SRCS; i++) begin : g_src
        assign push_s[i]    = src_valid[i] && !fifo_full_s[i];
        assign pop_s[i]     = load_s && (grant_s == SRC_ID_W'(i));
        assign src_ready[i] = !fifo_full_s[i];
        assign fifo_ne_s[i] = (fifo_count_s[i] != CNT_W'(0));

        scpad_req_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (CLK),
            .rst_n (nRST),
            .push  (push_s[i]),
            .din   (src_req[i]),
            .pop   (pop_s[i]),
            .dout  (fifo_dout_s[i]),
            .full  (fifo_full_s[i]),
            .empty (fifo_empty_s[i]),
            .count (fifo_count_s[i])
        );
    end

    // Round-robin search starting one past the last granted source
    always_comb begin
        grant_s       = '0;
        grant_found_s = 1'b0;
        search_s      = rr_last_r;
        for (int k = 0; k < NUM_SRCS; k++) begin
            search_s = (search_s == SRC_ID_W'(NUM_SRCS - 1)) ? SRC_ID_W'(0) : search_s + SRC_ID_W'(1);
            if (!grant_found_s && !fifo_empty_s[search_s]) begin
                grant_s       = search_s;
                grant_found_s = 1'b1;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Output register may refill when empty or being drained this cycle
    always_comb begin
        load_s = (!out_valid_r || out_ready) && grant_found_s;
    end

    // Output stage and arbitration pointer; a stalled output holds everything
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            out_valid_r <= 1'b0;
            out_req_r   <= '0;
            out_src_r   <= '0;
            rr_last_r   <= SRC_ID_W'(NUM_SRCS - 1);
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_req_r   <= fifo_dout_s[grant_s];
            out_src_r   <= grant_s;
            rr_last_r   <= grant_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign out_valid = out_valid_r;
    assign out_req   = out_req_r;
    assign out_src   = out_src_r;
    assign busy      = out_valid_r || (|fifo_ne_s);

endmodule

// File: tb/tb_scpad_req_arbiter.sv
// Scoreboard bench for scpad_req_arbiter: accepted requests are queued per
// source and a negedge monitor checks every output handshake against them.
module tb_scpad_req_arbiter;
    import scpad_pkg::*;

    localparam int NS    = 3;
    localparam int DEPTH = 4;
    localparam int SW    = $clog2(NS);

    logic                   CLK = 1'b0;
    logic                   nRST;
    logic       [NS-1:0]    src_valid;
    logic       [NS-1:0]    src_ready;
    scpad_req_t [NS-1:0]    src_req;
    logic                   out_valid;
    logic                   out_ready;
    scpad_req_t             out_req;
    logic       [SW-1:0]    out_src;
    logic                   busy;

    scpad_req_arbiter #(.NUM_SRCS(NS), .FIFO_DEPTH(DEPTH), .SRC_ID_W(SW)) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .src_req   (src_req),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_req   (out_req),
        .out_src   (out_src),
        .busy      (busy)
    );

    always #5 CLK = ~CLK;

    typedef scpad_req_t req_q_t[$];
    req_q_t     exp_q [NS];
    int         grant_log[$];
    int         checks = 0;
    int         failures = 0;
    int         accepts = 0;
    int         handshakes = 0;
    int         wait_cnt [NS];
    int         max_wait = 0;
    int         mon_s;
    scpad_req_t mon_exp;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic scpad_req_t mk_req(input int src, input int seq);
        scpad_req_t r;
        r.write    = seq[0];
        r.scpad_id = src[0];
        r.addr     = ROW_ADDR_W'(src * 64 + seq);
        r.mask     = NUM_COLS'(seq + 1);
        r.data     = {8'(seq), 8'(src), 8'hA5, 8'(seq ^ 8'h5A)};
        return r;
    endfunction

    function automatic bit all_q_empty();
        for (int i = 0; i < NS; i++) if (exp_q[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Handshake checker first, then record requests accepted at the coming edge
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if (out_valid && out_ready) begin
                mon_s = int'(out_src);
                handshakes++;
                grant_log.push_back(mon_s);
                checks++;
                if (mon_s >= NS || exp_q[mon_s].size() == 0) begin
                    failures++;
                    $display("FAIL out_unexpected src=%0d req=%0h", mon_s, out_req);
                end else begin
                    mon_exp = exp_q[mon_s].pop_front();
                    if (out_req !== mon_exp) begin
                        failures++;
                        $display("FAIL out_req src=%0d actual=%0h expected=%0h", mon_s, out_req, mon_exp);
                    end
                    for (int i = 0; i < NS; i++) begin
                        if (i == mon_s || exp_q[i].size() == 0) wait_cnt[i] = 0;
                        else wait_cnt[i]++;
                        if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
                    end
                end
            end
            for (int i = 0; i < NS; i++) begin
                if (src_valid[i] && src_ready[i]) begin
                    exp_q[i].push_back(src_req[i]);
                    accepts++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        src_valid = '0;
        out_ready = 1'b0;
        #3 nRST = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_out_src", 64'(out_src), 64'(0));
        chk("rst_out_req", 64'(out_req), 64'(0));
        for (int i = 0; i < NS; i++) begin
            exp_q[i].delete();
            wait_cnt[i] = 0;
        end
        tick();
        tick();
        nRST = 1'b1;
        tick();
        chk("rst_src_ready", 64'(src_ready), 64'(3'b111));
    endtask

    task automatic wait_drain(input string name, input int maxc);
        for (int c = 0; c < maxc; c++) begin
            if (!out_valid && all_q_empty()) break;
            tick();
        end
        chk(name, 64'(!out_valid && all_q_empty()), 64'(1));
    endtask

    // Streams sequential requests on one source until `target` are accepted
    task automatic stream(input int src, input int base, input int target, input int maxc, output int nacc);
        int  seq;
        bit  acc;
        seq = 0;
        for (int c = 0; c < maxc && seq < target; c++) begin
            src_req[src]   = mk_req(src, base + seq);
            src_valid[src] = 1'b1;
            acc            = src_ready[src];
            tick();
            if (acc) seq++;
        end
        src_valid[src] = 1'b0;
        nacc = seq;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        scpad_req_t req1;
        scpad_req_t held;
        bit         have;
        bit         ok;
        int         nacc;
        int         h0;
        int         a0;
        int         rseq [NS];
        bit         acc_prev [NS];

        nRST      = 1'b0;
        src_valid = '0;
        out_ready = 1'b0;
        src_req   = '0;
        tick();
        do_reset();

        // Single write from src1 and its two-edge latency
        req1.write    = 1'b1;
        req1.scpad_id = 1'b1;
        req1.addr     = 8'h10;
        req1.mask     = 4'hF;
        req1.data     = 32'hA5A5_A5A5;
        src_req[1]   = req1;
        src_valid[1] = 1'b1;
        tick();
        src_valid[1] = 1'b0;
        chk("t1_not_yet_valid", 64'(out_valid), 64'(0));
        chk("t1_busy_queued", 64'(busy), 64'(1));
        tick();
        chk("t1_valid", 64'(out_valid), 64'(1));
        chk("t1_src", 64'(out_src), 64'(1));
        chk("t1_req", 64'(out_req), 64'(req1));
        out_ready = 1'b1;
        tick();
        chk("t1_valid_clear", 64'(out_valid), 64'(0));
        chk("t1_busy_clear", 64'(busy), 64'(0));

        // Three sources push four each; grants rotate 0,1,2
        do_reset();
        grant_log.delete();
        out_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < NS; i++) src_req[i] = mk_req(i, n);
            src_valid = 3'b111;
            chk("t2_ready", 64'(src_ready), 64'(3'b111));
            tick();
        end
        src_valid = '0;
        wait_drain("t2_drain", 40);
        chk("t2_count", 64'(grant_log.size()), 64'(12));
        ok = (grant_log.size() == 12);
        for (int k = 0; k < grant_log.size(); k++) if (grant_log[k] != k % NS) ok = 1'b0;
        chk("t2_grant_order", 64'(ok), 64'(1));

        // Stalled output while src0 streams: held stable, FIFO fills
        out_ready = 1'b0;
        have = 1'b0;
        ok   = 1'b1;
        nacc = 0;
        for (int c = 0; c < 10; c++) begin
            bit acc;
            src_req[0]   = mk_req(0, 100 + nacc);
            src_valid[0] = 1'b1;
            acc          = src_ready[0];
            tick();
            if (acc) nacc++;
            if (out_valid) begin
                if (!have) begin
                    held = out_req;
                    have = 1'b1;
                end else if (out_req !== held) begin
                    ok = 1'b0;
                end
            end
        end
        src_valid[0] = 1'b0;
        chk("t3_accepted", 64'(nacc), 64'(DEPTH + 1));
        chk("t3_ready_low", 64'(src_ready[0]), 64'(0));
        chk("t3_stable", 64'(ok && have), 64'(1));
        chk("t3_held_req", 64'(held), 64'(mk_req(0, 100)));
        chk("t3_held_src", 64'(out_src), 64'(0));
        out_ready = 1'b1;
        tick();
        chk("t3_ready_back", 64'(src_ready[0]), 64'(1));
        ok = out_valid;
        for (int k = 0; k < 3; k++) begin
            tick();
            ok = ok && out_valid;
        end
        tick();
        chk("t3_back_to_back", 64'(ok), 64'(1));
        chk("t3_drained", 64'(out_valid), 64'(0));

        // Full src2 FIFO popping while still offered a request; then wrap
        out_ready = 1'b0;
        stream(2, 400, DEPTH + 1, 12, nacc);
        chk("t4_filled", 64'(nacc), 64'(DEPTH + 1));
        h0 = handshakes;
        src_req[2]   = mk_req(2, 400 + DEPTH + 1);
        src_valid[2] = 1'b1;
        out_ready    = 1'b1;
        chk("t4_ready_full_pop", 64'(src_ready[2]), 64'(0));
        tick();
        chk("t4_ready_after_pop", 64'(src_ready[2]), 64'(1));
        stream(2, 400 + DEPTH + 1, 16, 60, nacc);
        chk("t4_wrap_accepted", 64'(nacc), 64'(16));
        wait_drain("t4_drain", 40);
        chk("t4_outputs", 64'(handshakes - h0), 64'(DEPTH + 1 + 16));

        // Reset mid-burst discards held and queued requests
        out_ready = 1'b0;
        stream(0, 600, 4, 8, nacc);
        chk("t5_pre_valid", 64'(out_valid), 64'(1));
        do_reset();
        grant_log.delete();
        for (int i = 0; i < NS; i++) src_req[i] = mk_req(i, 200);
        src_valid = 3'b111;
        tick();
        src_valid = '0;
        out_ready = 1'b1;
        wait_drain("t5_drain", 20);
        ok = (grant_log.size() == 3);
        for (int k = 0; k < grant_log.size(); k++) if (grant_log[k] != k) ok = 1'b0;
        chk("t5_post_reset_order", 64'(ok), 64'(1));

        // Random traffic with random back-pressure
        a0 = accepts;
        h0 = handshakes;
        for (int i = 0; i < NS; i++) begin
            rseq[i]     = 0;
            acc_prev[i] = 1'b0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NS; i++) begin
                if (!src_valid[i] || acc_prev[i]) begin
                    src_valid[i] = ($urandom_range(0, 3) != 0);
                    src_req[i]   = mk_req(i, 1000 + rseq[i]);
                    rseq[i]++;
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            for (int i = 0; i < NS; i++) acc_prev[i] = src_valid[i] && src_ready[i];
            tick();
        end
        src_valid = '0;
        out_ready = 1'b1;
        wait_drain("t6_drain", 100);
        chk("t6_in_equals_out", 64'(accepts - a0), 64'(handshakes - h0));
        chk("t6_starvation_bound", 64'(max_wait <= NS), 64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
